// File: rtl/pd_buffer_stage_pkg.sv
// Shared types and constants for the pre-decode buffer stage.
// XLEN fixes the width of PC, link and BTB target fields in both the
// IF->PD parcel and the PD->ID queue entry.
package pd_buffer_stage_pkg;

  localparam int XLEN                    = 32;
  localparam int PD_BUFFER_DEPTH_DEFAULT = 4;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Parcel handed over by IF: raw candidates plus the one-hot selection
  typedef struct packed {
    logic            sel_nop;
    logic            sel_spanning;
    logic            sel_compressed;
    logic [15:0]     compressed_instr;
    logic [31:0]     spanning_instr;
    logic [31:0]     effective_instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] link_address;
    logic            btb_hit;
    logic            btb_predicted_taken;
    logic [XLEN-1:0] btb_predicted_target;
  } from_if_to_pd_t;

  // Pre-decoded entry; also the element type of the elastic queue
  typedef struct packed {
    logic [31:0]     instruction;
    logic [4:0]      source_reg_1_early;
    logic [4:0]      source_reg_2_early;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] link_address;
    logic            btb_hit;
    logic            btb_predicted_taken;
    logic [XLEN-1:0] btb_predicted_target;
    logic            illegal_instr;
  } from_pd_to_id_t;

  // Occupancy classes derived from the entry count
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occupancy_t;

  // What ID sees whenever the queue is empty
  function automatic from_pd_to_id_t idle_entry();
    from_pd_to_id_t e;
    e             = '0;
    e.instruction = NOP;
    return e;
  endfunction

endpackage

// File: rtl/pd_buffer_stage_if.sv
// Handshake bundle between IF, the pre-decode buffer and ID.
// slave  : the buffer stage itself.
// master : the surrounding pipeline (IF producer + ID consumer).
interface pd_buffer_stage_if;
  import pd_buffer_stage_pkg::*;

  logic           i_valid;
  logic           o_ready;
  from_if_to_pd_t i_from_if_to_pd;
  logic           o_valid;
  logic           i_ready;
  from_pd_to_id_t o_from_pd_to_id;

  modport slave (
    input  i_valid, i_from_if_to_pd, i_ready,
    output o_ready, o_valid, o_from_pd_to_id
  );

  modport master (
    output i_valid, i_from_if_to_pd, i_ready,
    input  o_ready, o_valid, o_from_pd_to_id
  );

endinterface

// File: rtl/pd_buffer_stage_rvc_decompressor.sv
// RV32C -> RV32I expander. Integer forms only: the compressed
// floating-point loads/stores and RV64/128-only encodings are reported
// as illegal, and an illegal parcel always expands to NOP.
module rvc_decompressor
  import pd_buffer_stage_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic [31:0] o_instr,
  output logic        o_illegal
);

  logic [15:0] c;
  assign c = i_instr;

  // Decode by quadrant and funct3, then rebuild the 32-bit encoding
  always_comb begin
    o_instr   = NOP;
    o_illegal = 1'b0;
    case ({c[1:0], c[15:13]})
      5'b00_000: begin  // c.addi4spn
        o_instr   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, 2'b01, c[4:2], 7'b0010011};
        o_illegal = (c[12:5] == 8'd0);
      end
      5'b00_010:        // c.lw
        o_instr = {5'b0, c[5], c[12:10], c[6], 2'b00, 2'b01, c[9:7], 3'b010, 2'b01, c[4:2], 7'b0000011};
      5'b00_110:        // c.sw
        o_instr = {5'b0, c[5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
      5'b01_000:        // c.addi / c.nop
        o_instr = {{7{c[12]}}, c[6:2], c[11:7], 3'b000, c[11:7], 7'b0010011};
      5'b01_001:        // c.jal
        o_instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}, 5'd1, 7'b1101111};
      5'b01_010:        // c.li
        o_instr = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, c[11:7], 7'b0010011};
      5'b01_011: begin
        if (c[11:7] == 5'd2) begin  // c.addi16sp
          o_instr = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'b0010011};
        end else begin              // c.lui
          o_instr = {{15{c[12]}}, c[6:2], c[11:7], 7'b0110111};
        end
        o_illegal = ({c[12], c[6:2]} == 6'd0);
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: begin  // c.srli
            o_instr   = {7'b0000000, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], 7'b0010011};
            o_illegal = c[12];
          end
          2'b01: begin  // c.srai
            o_instr   = {7'b0100000, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], 7'b0010011};
            o_illegal = c[12];
          end
          2'b10:        // c.andi
            o_instr = {{7{c[12]}}, c[6:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], 7'b0010011};
          default: begin  // c.sub / c.xor / c.or / c.and
            case (c[6:5])
              2'b00:   o_instr = {7'b0100000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b000, 2'b01, c[9:7], 7'b0110011};
              2'b01:   o_instr = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b100, 2'b01, c[9:7], 7'b0110011};
              2'b10:   o_instr = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b110, 2'b01, c[9:7], 7'b0110011};
              default: o_instr = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], 7'b0110011};
            endcase
            o_illegal = c[12];
          end
        endcase
      end
      5'b01_101:        // c.j
        o_instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}, 5'd0, 7'b1101111};
      5'b01_110:        // c.beqz
        o_instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, 2'b01, c[9:7], 3'b000, c[11:10], c[4:3], c[12], 7'b1100011};
      5'b01_111:        // c.bnez
        o_instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, 2'b01, c[9:7], 3'b001, c[11:10], c[4:3], c[12], 7'b1100011};
      5'b10_000: begin  // c.slli
        o_instr   = {7'b0000000, c[6:2], c[11:7], 3'b001, c[11:7], 7'b0010011};
        o_illegal = c[12];
      end
      5'b10_010: begin  // c.lwsp
        o_instr   = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], 7'b0000011};
        o_illegal = (c[11:7] == 5'd0);
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (c[6:2] == 5'd0) begin  // c.jr
            o_instr   = {12'd0, c[11:7], 3'b000, 5'd0, 7'b1100111};
            o_illegal = (c[11:7] == 5'd0);
          end else begin             // c.mv
            o_instr = {7'b0000000, c[6:2], 5'd0, 3'b000, c[11:7], 7'b0110011};
          end
        end else begin
          if (c[6:2] == 5'd0) begin
            if (c[11:7] == 5'd0) o_instr = 32'h0010_0073;                              // c.ebreak
            else                 o_instr = {12'd0, c[11:7], 3'b000, 5'd1, 7'b1100111}; // c.jalr
          end else begin             // c.add
            o_instr = {7'b0000000, c[6:2], c[11:7], 3'b000, c[11:7], 7'b0110011};
          end
        end
      end
      5'b10_110:        // c.swsp
        o_instr = {4'b0000, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) o_instr = NOP;
  end

endmodule

// File: rtl/pd_buffer_stage.sv
// Pre-decode stage with a DEPTH-entry elastic queue between IF and ID.
// Each accepted parcel is resolved to its final 32-bit instruction,
// early rs1/rs2 are extracted, and the result is queued for ID.
// Optional feature macro: FROST_PD_RVC_EN builds the RVC decompressor;
// without it a compressed parcel is queued as NOP flagged illegal.
module pd_buffer_stage
  import pd_buffer_stage_pkg::*;
#(
  parameter int DEPTH = PD_BUFFER_DEPTH_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  pd_buffer_stage_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  from_if_to_pd_t   parcel;
  logic [31:0]      decomp_instr;
  logic             decomp_illegal;
  logic [31:0]      final_instr;
  from_pd_to_id_t   entry_in;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  occupancy_t       occupancy;
  logic             valid_int;
  logic             ready_int;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] slot_we;
  from_pd_to_id_t   slot_q [DEPTH];

  assign parcel = bus.i_from_if_to_pd;

`ifdef FROST_PD_RVC_EN
  rvc_decompressor u_rvc_decompressor (
    .i_instr   (parcel.compressed_instr),
    .o_instr   (decomp_instr),
    .o_illegal (decomp_illegal)
  );
`else
  // No expander: compressed parcels become an illegal-instruction trap in ID
  logic [15:0] unused_compressed_instr;
  assign unused_compressed_instr = parcel.compressed_instr;
  assign decomp_instr   = NOP;
  assign decomp_illegal = 1'b1;
`endif

  // Resolve the one-hot selection; plain 32-bit is the fallthrough case
  always_comb begin
    final_instr = parcel.effective_instr;
    if (parcel.sel_nop)             final_instr = NOP;
    else if (parcel.sel_spanning)   final_instr = parcel.spanning_instr;
    else if (parcel.sel_compressed) final_instr = decomp_instr;
  end

  // Assemble the queue entry from the resolved instruction and IF metadata
  always_comb begin
    entry_in                      = '0;
    entry_in.instruction          = final_instr;
    entry_in.source_reg_1_early   = final_instr[19:15];
    entry_in.source_reg_2_early   = final_instr[24:20];
    entry_in.pc                   = parcel.pc;
    entry_in.link_address         = parcel.link_address;
    entry_in.btb_hit              = parcel.btb_hit;
    entry_in.btb_predicted_taken  = parcel.btb_predicted_taken;
    entry_in.btb_predicted_target = parcel.btb_predicted_target;
    entry_in.illegal_instr        = parcel.sel_compressed && decomp_illegal;
  end

  // Classify occupancy; ready/valid depend only on registered count
  always_comb begin
    occupancy = OCC_PARTIAL;
    if (count_reg == '0)             occupancy = OCC_EMPTY;
    else if (count_reg == FULL_COUNT) occupancy = OCC_FULL;
  end

  assign ready_int   = (occupancy != OCC_FULL);
  assign valid_int   = (occupancy != OCC_EMPTY);
  assign bus.o_ready = ready_int;
  assign bus.o_valid = valid_int;

  assign push = bus.i_valid && ready_int && !i_flush;
  assign pop  = valid_int && bus.i_ready && !i_flush;

  // Next pointers and count; a flush empties the queue and suppresses push/pop
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer and count registers; reset drops every entry at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry slots: payload only, never reset since count gates visibility
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      from_pd_to_id_t slot_reg;

      assign slot_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));

      // Capture the pre-decoded parcel when this slot is the write target
      always_ff @(posedge i_clk) begin
        if (slot_we[gi]) slot_reg <= entry_in;
      end

      assign slot_q[gi] = slot_reg;
    end
  endgenerate

  assign bus.o_from_pd_to_id = valid_int ? slot_q[rd_ptr_reg] : idle_entry();

endmodule

// File: tb/tb_pd_buffer_stage.sv
// Directed bench for pd_buffer_stage at DEPTH=4. Inputs change and
// outputs are sampled on the falling edge, away from the active edge.
module tb_pd_buffer_stage;
  import pd_buffer_stage_pkg::*;

  localparam int DEPTH  = 4;
  localparam int K_32   = 0;
  localparam int K_C    = 1;
  localparam int K_SPAN = 2;
  localparam int K_NOP  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  pd_buffer_stage_if bus_if ();

  pd_buffer_stage #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus_if.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  from_pd_to_id_t head;

  function automatic from_if_to_pd_t mk_parcel(input logic [31:0] pc, input int kind,
                                               input logic [31:0] word, input logic btb);
    from_if_to_pd_t p;
    p                      = '0;
    p.pc                   = pc;
    p.link_address         = pc + 32'd4;
    p.effective_instr      = word;
    p.btb_hit              = btb;
    p.btb_predicted_taken  = btb;
    p.btb_predicted_target = btb ? 32'h0000_0500 : 32'h0;
    case (kind)
      K_C: begin
        p.sel_compressed   = 1'b1;
        p.compressed_instr = word[15:0];
        p.effective_instr  = 32'hFFFF_FFFF;
        p.link_address     = pc + 32'd2;
      end
      K_SPAN: begin
        p.sel_spanning    = 1'b1;
        p.spanning_instr  = word;
        p.effective_instr = 32'hFFFF_FFFF;
      end
      K_NOP: p.sel_nop = 1'b1;
      default: ;
    endcase
    return p;
  endfunction

  task automatic test_reset();
    from_pd_to_id_t exp_idle;
    exp_idle             = '0;
    exp_idle.instruction = NOP;
    rst_n = 1'b0;
    flush = 1'b0;
    bus_if.i_valid = 1'b0;
    bus_if.i_ready = 1'b0;
    bus_if.i_from_if_to_pd = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus_if.o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_o_valid: got %b expected 0", bus_if.o_valid);
    end
    tests_run++;
    if (bus_if.o_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_o_ready: got %b expected 1", bus_if.o_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    head = bus_if.o_from_pd_to_id;
    tests_run++;
    if (head !== exp_idle) begin
      tests_failed++; $display("FAIL reset_idle_pattern: got %h expected %h", head, exp_idle);
    end
    tests_run++;
    if (int'(dut.count_reg) !== 0 || bus_if.o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_count: got count=%0d valid=%b expected 0/0", dut.count_reg, bus_if.o_valid);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_single_32bit();
    bus_if.i_ready = 1'b1;
    bus_if.i_valid = 1'b1;
    bus_if.i_from_if_to_pd = mk_parcel(32'h100, K_32, 32'h00A5_0533, 1'b0);
    @(negedge clk);
    bus_if.i_valid = 1'b0;
    head = bus_if.o_from_pd_to_id;
    $display("[TB] pop pc=%h instr=%h", head.pc, head.instruction);
    tests_run++;
    if (bus_if.o_valid !== 1'b1 || head.instruction !== 32'h00A5_0533) begin
      tests_failed++; $display("FAIL single_instr: got valid=%b instr=%h expected 1/00a50533", bus_if.o_valid, head.instruction);
    end
    tests_run++;
    if (head.source_reg_1_early !== 5'd10 || head.source_reg_2_early !== 5'd10) begin
      tests_failed++; $display("FAIL single_rs: got rs1=%0d rs2=%0d expected 10/10", head.source_reg_1_early, head.source_reg_2_early);
    end
    tests_run++;
    if (head.pc !== 32'h100 || head.link_address !== 32'h104 || head.illegal_instr !== 1'b0) begin
      tests_failed++; $display("FAIL single_meta: got pc=%h link=%h ill=%b expected 100/104/0", head.pc, head.link_address, head.illegal_instr);
    end
    @(negedge clk);
    tests_run++;
    if (bus_if.o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_drain: got valid=%b expected 0", bus_if.o_valid);
    end
  endtask

  task automatic test_selection();
    int          kinds     [3] = '{K_C, K_SPAN, K_NOP};
    logic [31:0] words     [3] = '{32'h0000_0405, 32'h00C5_8633, 32'h00A5_0533};
    logic [31:0] exp_instr [3];
    logic        exp_ill   [3];
    logic [4:0]  exp_rs1   [3];
`ifdef FROST_PD_RVC_EN
    exp_instr[0] = 32'h0014_0413; exp_ill[0] = 1'b0; exp_rs1[0] = 5'd8;
`else
    exp_instr[0] = NOP;           exp_ill[0] = 1'b1; exp_rs1[0] = 5'd0;
`endif
    exp_instr[1] = 32'h00C5_8633; exp_ill[1] = 1'b0; exp_rs1[1] = 5'd11;
    exp_instr[2] = NOP;           exp_ill[2] = 1'b0; exp_rs1[2] = 5'd0;
    bus_if.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus_if.i_valid = 1'b1;
      bus_if.i_from_if_to_pd = mk_parcel(32'h140 + 32'(4 * k), kinds[k], words[k], 1'b0);
      @(negedge clk);
      bus_if.i_valid = 1'b0;
      head = bus_if.o_from_pd_to_id;
      $display("[TB] pop pc=%h instr=%h ill=%b", head.pc, head.instruction, head.illegal_instr);
      tests_run++;
      if (bus_if.o_valid !== 1'b1 || head.instruction !== exp_instr[k] || head.illegal_instr !== exp_ill[k]) begin
        tests_failed++;
        $display("FAIL select_%0d: got valid=%b instr=%h ill=%b expected 1/%h/%b",
                 k, bus_if.o_valid, head.instruction, head.illegal_instr, exp_instr[k], exp_ill[k]);
      end
      tests_run++;
      if (head.source_reg_1_early !== exp_rs1[k]) begin
        tests_failed++; $display("FAIL select_rs1_%0d: got %0d expected %0d", k, head.source_reg_1_early, exp_rs1[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_full_backpressure();
    logic [31:0] exp_pc [3] = '{32'h208, 32'h20C, 32'h210};
    bus_if.i_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus_if.i_valid = 1'b1;
      bus_if.i_from_if_to_pd = mk_parcel(32'h200 + 32'(4 * k), K_32, 32'h0010_0093, 1'b0);
      @(negedge clk);
      $display("[TB] push pc=%h", 32'h200 + 32'(4 * k));
    end
    bus_if.i_from_if_to_pd = mk_parcel(32'h210, K_32, 32'h0010_0093, 1'b0);
    tests_run++;
    if (bus_if.o_ready !== 1'b0 || int'(dut.count_reg) !== DEPTH) begin
      tests_failed++; $display("FAIL full_state: got ready=%b count=%0d expected 0/%0d", bus_if.o_ready, dut.count_reg, DEPTH);
    end
    @(negedge clk);
    head = bus_if.o_from_pd_to_id;
    tests_run++;
    if (bus_if.o_ready !== 1'b0 || int'(dut.count_reg) !== DEPTH || head.pc !== 32'h200) begin
      tests_failed++; $display("FAIL full_hold: got ready=%b count=%0d head=%h expected 0/%0d/200", bus_if.o_ready, dut.count_reg, head.pc, DEPTH);
    end
    bus_if.i_ready = 1'b1;
    #1;
    tests_run++;
    if (bus_if.o_ready !== 1'b0) begin
      tests_failed++; $display("FAIL full_no_comb_ready: got %b expected 0", bus_if.o_ready);
    end
    @(negedge clk);
    head = bus_if.o_from_pd_to_id;
    tests_run++;
    if (int'(dut.count_reg) !== DEPTH - 1 || bus_if.o_ready !== 1'b1 || head.pc !== 32'h204) begin
      tests_failed++; $display("FAIL full_pop: got count=%0d ready=%b head=%h expected %0d/1/204", dut.count_reg, bus_if.o_ready, head.pc, DEPTH - 1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus_if.i_valid = 1'b0;
      head = bus_if.o_from_pd_to_id;
      $display("[TB] pop pc=%h", head.pc);
      tests_run++;
      if (bus_if.o_valid !== 1'b1 || head.pc !== exp_pc[k]) begin
        tests_failed++; $display("FAIL drain_%0d: got valid=%b pc=%h expected 1/%h", k, bus_if.o_valid, head.pc, exp_pc[k]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus_if.o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL drain_empty: got valid=%b expected 0", bus_if.o_valid);
    end
  endtask

  task automatic test_flush();
    from_pd_to_id_t exp_idle;
    exp_idle             = '0;
    exp_idle.instruction = NOP;
    bus_if.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_if.i_valid = 1'b1;
      bus_if.i_from_if_to_pd = mk_parcel(32'h300 + 32'(4 * k), K_32, 32'h00A5_0533, 1'b1);
      @(negedge clk);
    end
    head = bus_if.o_from_pd_to_id;
    tests_run++;
    if (int'(dut.count_reg) !== 3 || head.btb_hit !== 1'b1 || head.btb_predicted_target !== 32'h500) begin
      tests_failed++; $display("FAIL flush_prefill: got count=%0d btb=%b tgt=%h expected 3/1/500", dut.count_reg, head.btb_hit, head.btb_predicted_target);
    end
    flush = 1'b1;
    bus_if.i_ready = 1'b1;
    bus_if.i_from_if_to_pd = mk_parcel(32'h30C, K_32, 32'h00A5_0533, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    bus_if.i_valid = 1'b0;
    head = bus_if.o_from_pd_to_id;
    $display("[TB] flush applied");
    tests_run++;
    if (bus_if.o_valid !== 1'b0 || int'(dut.count_reg) !== 0 || bus_if.o_ready !== 1'b1) begin
      tests_failed++; $display("FAIL flush_state: got valid=%b count=%0d ready=%b expected 0/0/1", bus_if.o_valid, dut.count_reg, bus_if.o_ready);
    end
    tests_run++;
    if (head !== exp_idle) begin
      tests_failed++; $display("FAIL flush_idle_pattern: got %h expected %h", head, exp_idle);
    end
    @(negedge clk);
    tests_run++;
    if (bus_if.o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_dropped_parcel: got valid=%b expected 0", bus_if.o_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus_if.i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus_if.i_valid = 1'b1;
      bus_if.i_from_if_to_pd = mk_parcel(32'h600 + 32'(4 * k), K_32, 32'h00A5_0533, 1'b0);
      @(negedge clk);
      head = bus_if.o_from_pd_to_id;
      $display("[TB] pop pc=%h", head.pc);
      tests_run++;
      if (bus_if.o_valid !== 1'b1 || head.pc !== 32'h600 + 32'(4 * k) || int'(dut.count_reg) !== 1) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got valid=%b pc=%h count=%0d expected 1/%h/1",
                 k, bus_if.o_valid, head.pc, dut.count_reg, 32'h600 + 32'(4 * k));
      end
    end
    bus_if.i_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus_if.o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_empty: got valid=%b expected 0", bus_if.o_valid);
    end
  endtask

  task automatic test_async_reset();
    bus_if.i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_if.i_valid = 1'b1;
      bus_if.i_from_if_to_pd = mk_parcel(32'h700 + 32'(4 * k), K_32, 32'h00A5_0533, 1'b0);
      @(negedge clk);
    end
    bus_if.i_valid = 1'b0;
    tests_run++;
    if (bus_if.o_valid !== 1'b1 || int'(dut.count_reg) !== 2) begin
      tests_failed++; $display("FAIL arst_prefill: got valid=%b count=%0d expected 1/2", bus_if.o_valid, dut.count_reg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.o_valid !== 1'b0 || bus_if.o_ready !== 1'b1 || int'(dut.count_reg) !== 0) begin
      tests_failed++; $display("FAIL arst_immediate: got valid=%b ready=%b count=%0d expected 0/1/0", bus_if.o_valid, bus_if.o_ready, dut.count_reg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_if.o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL arst_no_stale: got valid=%b expected 0", bus_if.o_valid);
    end
    bus_if.i_valid = 1'b1;
    bus_if.i_from_if_to_pd = mk_parcel(32'h800, K_32, 32'h00A5_0533, 1'b0);
    @(negedge clk);
    bus_if.i_valid = 1'b0;
    head = bus_if.o_from_pd_to_id;
    $display("[TB] push after reset pc=%h", head.pc);
    tests_run++;
    if (head.pc !== 32'h800 || int'(dut.count_reg) !== 1) begin
      tests_failed++; $display("FAIL arst_fresh_head: got pc=%h count=%0d expected 800/1", head.pc, dut.count_reg);
    end
  endtask

  initial begin
    test_reset();
    test_single_32bit();
    test_selection();
    test_full_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
